memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Single-port memory arbiter between the CPU's instruction-fetch and data-access paths and the shared RAM. Grants one requester at a time through a registered FSM with data priority and instruction-after-data fairness. Returns the `ihit`/`dhit` pulses that the request unit and pipeline consume, and flags a watchdog timeout or RAM error.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum cycles a grant may wait for `ACCESS` before it is aborted.

Ports:
- `CLK` in 1: system clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high. Single clock domain.
- `iREN` in 1: instruction fetch request.
- `iaddr` in 32: fetch address.
- `iload` out 32: fetched word; valid only while `ihit`=1.
- `ihit` out 1: one-cycle fetch completion.
- `dREN` in 1: data read request.
- `dWEN` in 1: data write request.
- `daddr` in 32: data address.
- `dstore` in 32: write data.
- `dload` out 32: read word; valid only while `dhit`=1.
- `dhit` out 1: one-cycle data completion.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramload` in 32: RAM read data.
- `ramstate` in `ramstate_t`: RAM status, one of `FREE`, `BUSY`, `ACCESS`, `ERROR`.
- `err` out 1: sticky fault flag.

## Operation
- FSM states `IDLE`, `DGNT`, `IGNT`, held in a registered state, reset value `IDLE`.
- Requests are level signals. The requester holds the address and data stable until it sees a hit or drops the request.
- `IDLE` transitions, evaluated each cycle:
  - `dREN|dWEN` → `DGNT`.
  - else `iREN` → `IGNT`.
  - else stay in `IDLE`.
  - Data wins any simultaneous request.
- `DGNT` outputs:
  - `ramaddr=daddr`, `ramstore=dstore`.
  - `ramWEN=dWEN`, `ramREN=dREN&~dWEN`. Write wins if both enables are high.
- `IGNT` outputs: `ramaddr=iaddr`, `ramREN=1`, `ramWEN=0`, `ramstore=0`.
- In `IDLE`, all RAM outputs are 0.
- Completion: a grant state with `ramstate==ACCESS` drives the matching hit=1 combinationally that cycle, and `iload` or `dload` = `ramload`.
- Next state after completion:
  - From `DGNT`: `IGNT` if `iREN`, else `DGNT` if a data request is still asserted (next access), else `IDLE`.
  - From `IGNT`: `DGNT` if a data request is pending, else `IGNT` if `iREN`, else `IDLE`.
  - Back-to-back grants therefore have no idle bubble.
- Withdrawal: if the granted requester drops its request before `ACCESS`, go to `IDLE` next cycle with no hit. RAM enables drop the same cycle.
- `ramstate==ERROR` in a grant state:
  - set `err`, return to `IDLE`, no hit.
  - The requester re-requests at its own discretion.
- Watchdog:
  - The counter clears on every grant entry and on every completion.
  - It increments each grant cycle without `ACCESS`.
  - When it reaches `TIMEOUT_CYCLES`: set `err`, abort to `IDLE`, no hit.
- `err` is sticky and is cleared only by `RST`.
- Hits are never asserted outside a grant state. `ihit` and `dhit` are never high together.

## Timing
- Reset values:
  - `state=IDLE`, counter=0, `err=0`.
  - All outputs 0: `ihit`, `dhit`, `iload`, `dload`, `ramaddr`, `ramstore`, `ramREN`, `ramWEN`.
- A request first seen in `IDLE` at cycle N gives the grant at N+1. The earliest hit is N+1, when the RAM returns `ACCESS` in its first enabled cycle.
- A RAM with k `BUSY` cycles gives the hit at N+1+k.
- `RST` asserted mid-grant forces `IDLE` and drops RAM enables immediately (asynchronously). No hit is issued for the in-flight access.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`. It saturates and never wraps.

## Structure
- Shared package `cpu_types_pkg`:
  - `ramstate_t` (`FREE`, `BUSY`, `ACCESS`, `ERROR`).
  - `arb_state_t` (`IDLE`, `DGNT`, `IGNT`).
  - `word_t` (32-bit).
- Ports are grouped in a `memory_arbiter_if` interface with `ma` and `tb` modports.
- One sub-module, `arb_watchdog`, is natural. It is a clear/increment/saturate counter with a `expired` output, parameterised by `TIMEOUT_CYCLES`.
- The FSM and output muxing stay in `memory_arbiter`.

## Test plan
- Simultaneous `dREN=1`, `daddr=0x100`, `iREN=1`, `iaddr=0x0`; RAM `ACCESS` immediately:
  - `dhit` at cycle 1 with `dload=ramload`.
  - `ihit` at cycle 2.
  - No idle cycle between them.
- `dREN=1` and `dWEN=1`, `dstore=0xDEADBEEF`:
  - `ramWEN=1`, `ramREN=0`, `ramstore=0xDEADBEEF`.
  - `dhit` on `ACCESS`.
- Fetch grant with RAM `BUSY` for 3 cycles, then `ACCESS`:
  - `ihit` exactly 4 cycles after the request.
  - `ramaddr=iaddr` held throughout.
- `TIMEOUT_CYCLES=8`, RAM stuck `BUSY`:
  - `err` rises after the 8th waiting cycle, FSM returns to `IDLE`, no hit.
  - `err` stays high until `RST`.
- `ramstate=ERROR` during `DGNT`: `err=1`, no `dhit`, next state `IDLE`. Pending `iREN` is granted on the following cycle.
- `RST` pulsed mid-`IGNT` with `BUSY`: `ramREN` drops asynchronously and all outputs read 0. After release, a held `iREN` is re-granted one cycle later.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM status, arbiter FSM states and the machine word.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {IDLE, DGNT, IGNT} arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the arbiter's requester and RAM-side signals.
interface memory_arbiter_if (input logic CLK, input logic RST);
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      ihit;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dhit;
  word_t     ramaddr;
  word_t     ramstore;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramload;
  ramstate_t ramstate;
  logic      err;

  modport ma (
    input  CLK, RST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, ihit, dload, dhit, ramaddr, ramstore, ramREN, ramWEN, err
  );

  modport tb (
    input  CLK, RST, iload, ihit, dload, dhit, ramaddr, ramstore, ramREN, ramWEN, err,
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate
  );

endinterface

// File: rtl/arb_watchdog.sv
// Grant watchdog: clear/increment/saturate counter that flags the cycle the
// count reaches TIMEOUT_CYCLES.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Fires on the waiting cycle whose increment brings the count to the limit.
  assign expired_c = inc_i && !clr_i && (cnt_q >= LIMIT - CNT_W'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, with data
// priority, instruction-after-data fairness, sticky error and grant watchdog.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      ihit,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dhit,
  output word_t     ramaddr,
  output word_t     ramstore,
  output logic      ramREN,
  output logic      ramWEN,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       err_q;
  logic       err_d;
  logic       d_req;
  logic       wd_clr;
  logic       wd_inc;
  logic       wd_expired;

  assign d_req  = dREN | dWEN;
  assign wd_clr = (state_q == IDLE) || (ramstate == ACCESS);
  assign wd_inc = (state_q != IDLE) && (ramstate != ACCESS);
  assign err    = err_q;

  arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clr_i     (wd_clr),
    .inc_i     (wd_inc),
    .expired_c (wd_expired)
  );

  // Next-state and RAM/hit muxing; outputs follow the registered state so
  // reset drops enables immediately.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d = DGNT;
        end else if (iREN) begin
          state_d = IGNT;
        end
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!d_req) begin
          state_d = IDLE;
        end else if (ramstate == ERROR) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          dhit    = 1'b1;
          dload   = ramload;
          state_d = iREN ? IGNT : DGNT;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ramstate == ERROR) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          ihit    = 1'b1;
          iload   = ramload;
          state_d = d_req ? DGNT : IGNT;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed requests, hits checked by a
// separate monitor against hand-computed expectations.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  typedef struct {
    logic  is_d;
    word_t data;
    int    cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  memory_arbiter_if mif (.CLK(clk), .RST(rst));

  // RAM read data is a fixed scramble of the address.
  assign mif.ramload = mif.ramaddr ^ 32'hA5A5_0000;

  memory_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .CLK      (mif.CLK),
    .RST      (mif.RST),
    .iREN     (mif.iREN),
    .iaddr    (mif.iaddr),
    .iload    (mif.iload),
    .ihit     (mif.ihit),
    .dREN     (mif.dREN),
    .dWEN     (mif.dWEN),
    .daddr    (mif.daddr),
    .dstore   (mif.dstore),
    .dload    (mif.dload),
    .dhit     (mif.dhit),
    .ramaddr  (mif.ramaddr),
    .ramstore (mif.ramstore),
    .ramREN   (mif.ramREN),
    .ramWEN   (mif.ramWEN),
    .ramload  (mif.ramload),
    .ramstate (mif.ramstate),
    .err      (mif.err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every hit must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (mif.ihit || mif.dhit) begin
      checks++;
      if (mif.ihit && mif.dhit) begin
        failures++;
        $display("FAIL both_hits: ihit and dhit high together at cycle %0d", cyc);
      end else if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_hit: dhit=%0b ihit=%0b at cycle %0d, none expected",
                 mif.dhit, mif.ihit, cyc);
      end else begin
        e = sb_q.pop_front();
        if ((mif.dhit !== e.is_d) || (cyc != e.cyc) ||
            ((e.is_d ? mif.dload : mif.iload) !== e.data)) begin
          failures++;
          $display("FAIL hit: got dhit=%0b data=%h cycle=%0d, expected dhit=%0b data=%h cycle=%0d",
                   mif.dhit, (mif.dhit ? mif.dload : mif.iload), cyc, e.is_d, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic is_d, input word_t data, input int at);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    e.cyc  = at;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    mif.iREN = 1'b1; mif.iaddr = 32'h0;   mif.dREN = 1'b1; mif.dWEN = 1'b0;
    mif.daddr = 32'h100; mif.dstore = 32'h1234_5678; mif.ramstate = ACCESS;

    // Reset: all outputs zero even with requests and ACCESS present.
    @(negedge clk);
    chk("rst_ihit",   32'(mif.ihit), 32'd0);
    chk("rst_dhit",   32'(mif.dhit), 32'd0);
    chk("rst_iload",  mif.iload, 32'h0);
    chk("rst_dload",  mif.dload, 32'h0);
    chk("rst_ramaddr", mif.ramaddr, 32'h0);
    chk("rst_ramstore", mif.ramstore, 32'h0);
    chk("rst_ren_wen", {30'd0, mif.ramREN, mif.ramWEN}, 32'd0);
    chk("rst_err",    32'(mif.err), 32'd0);
    mif.iREN = 1'b0; mif.dREN = 1'b0; mif.dstore = 32'h0; mif.ramstate = FREE;
    tick();
    rst = 1'b0;

    // Simultaneous data and fetch: dhit then ihit back to back.
    c = cyc;
    mif.dREN = 1'b1; mif.daddr = 32'h100; mif.iREN = 1'b1; mif.iaddr = 32'h0;
    mif.ramstate = ACCESS;
    push(1'b1, 32'hA5A5_0100, c + 1);
    push(1'b0, 32'hA5A5_0000, c + 2);
    tick();
    tick();
    mif.dREN = 1'b0;
    @(negedge clk);
    chk("t1_ignt_ren", 32'(mif.ramREN), 32'd1);
    tick();
    mif.iREN = 1'b0; mif.ramstate = FREE;
    tick();
    tick();

    // Read+write together: write wins.
    c = cyc;
    mif.dREN = 1'b1; mif.dWEN = 1'b1; mif.daddr = 32'h200; mif.dstore = 32'hDEAD_BEEF;
    mif.ramstate = BUSY;
    tick();
    @(negedge clk);
    chk("t2_ramWEN",   32'(mif.ramWEN), 32'd1);
    chk("t2_ramREN",   32'(mif.ramREN), 32'd0);
    chk("t2_ramstore", mif.ramstore, 32'hDEAD_BEEF);
    chk("t2_ramaddr",  mif.ramaddr, 32'h200);
    tick();
    mif.ramstate = ACCESS;
    push(1'b1, 32'hA5A5_0200, c + 2);
    tick();
    mif.dREN = 1'b0; mif.dWEN = 1'b0; mif.dstore = 32'h0; mif.ramstate = FREE;
    tick();
    tick();

    // Fetch with three BUSY cycles: ihit four cycles after the request.
    c = cyc;
    mif.iREN = 1'b1; mif.iaddr = 32'h40; mif.ramstate = BUSY;
    push(1'b0, 32'hA5A5_0040, c + 4);
    for (int k = 1; k <= 3; k++) begin
      tick();
      @(negedge clk);
      chk("t3_ramaddr_busy", mif.ramaddr, 32'h40);
    end
    tick();
    mif.ramstate = ACCESS;
    @(negedge clk);
    chk("t3_ramaddr_access", mif.ramaddr, 32'h40);
    tick();
    mif.iREN = 1'b0; mif.ramstate = FREE;
    tick();

    // Asynchronous reset mid-fetch, then re-grant of the held request.
    c = cyc;
    mif.iREN = 1'b1; mif.iaddr = 32'hC0; mif.ramstate = BUSY;
    tick();
    @(negedge clk);
    chk("t6_ren_before_rst", 32'(mif.ramREN), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_ren_async", 32'(mif.ramREN), 32'd0);
    chk("t6_ramaddr_async", mif.ramaddr, 32'h0);
    chk("t6_hit_async", {30'd0, mif.ihit, mif.dhit}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_idle_after_release", 32'(mif.ramREN), 32'd0);
    tick();
    mif.ramstate = ACCESS;
    push(1'b0, 32'hA5A5_00C0, c + 3);
    @(negedge clk);
    chk("t6_regrant_addr", mif.ramaddr, 32'hC0);
    tick();
    mif.iREN = 1'b0; mif.ramstate = FREE;
    tick();

    // RAM ERROR during data grant; pending fetch granted right after.
    c = cyc;
    mif.dREN = 1'b1; mif.daddr = 32'h300; mif.iREN = 1'b1; mif.iaddr = 32'h80;
    tick();
    mif.ramstate = ERROR;
    @(negedge clk);
    chk("t5_err_before", 32'(mif.err), 32'd0);
    chk("t5_dgnt_ren", 32'(mif.ramREN), 32'd1);
    tick();
    mif.dREN = 1'b0; mif.ramstate = FREE;
    @(negedge clk);
    chk("t5_err_set", 32'(mif.err), 32'd1);
    chk("t5_idle_ren", 32'(mif.ramREN), 32'd0);
    tick();
    mif.ramstate = ACCESS;
    push(1'b0, 32'hA5A5_0080, c + 3);
    @(negedge clk);
    chk("t5_ignt_addr", mif.ramaddr, 32'h80);
    tick();
    mif.iREN = 1'b0; mif.ramstate = FREE;
    tick();
    @(negedge clk);
    chk("t5_err_sticky", 32'(mif.err), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t5_err_cleared", 32'(mif.err), 32'd0);
    tick();
    rst = 1'b0;

    // Watchdog: eight BUSY waiting cycles abort the grant and set err.
    c = cyc;
    mif.dREN = 1'b1; mif.daddr = 32'h400; mif.ramstate = BUSY;
    for (int k = 1; k <= 8; k++) begin
      tick();
      @(negedge clk);
      chk("t4_err_waiting", 32'(mif.err), 32'd0);
    end
    chk("t4_ren_waiting", 32'(mif.ramREN), 32'd1);
    tick();
    @(negedge clk);
    chk("t4_err_timeout", 32'(mif.err), 32'd1);
    chk("t4_idle_addr", mif.ramaddr, 32'h0);
    mif.dREN = 1'b0; mif.ramstate = FREE;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("t4_err_held", 32'(mif.err), 32'd1);
    end
    #1 rst = 1'b1;
    #1;
    chk("t4_err_rst", 32'(mif.err), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
